// File: rtl/fu_csr_wq_pkg.sv
// Shared types for the CSR functional unit: issue/writeback payloads, ROB retire entry,
// write-queue entry and the CSR read-modify-write helper.
package fu_csr_wq_pkg;
    localparam int XLEN = 32;
    localparam int ID_W = 5;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [ID_W-1:0] id_t;
    typedef logic [11:0]     csr_addr_t;
    typedef logic [5:0]      preg_t;
    typedef logic [1:0]      priv_lvl_t;

    localparam priv_lvl_t PRIV_LVL_M = 2'b11;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CSRR = 3'd1,
        OP_CSRW = 3'd2,
        OP_CSRS = 3'd3,
        OP_CSRC = 3'd4
    } fu_op_t;

    typedef struct packed {
        fu_op_t    op;
        logic [11:0] imm;
        xlen_t     rs1val;
        id_t       id;
        xlen_t     pc;
        preg_t     prd;
    } fu_input_t;

    typedef struct packed {
        xlen_t pc;
        id_t   id;
        preg_t prd;
        xlen_t rdval;
    } fu_output_t;

    typedef struct packed {
        id_t  id;
        logic csr_write;
    } rob_entry_t;

    typedef struct packed {
        id_t       id;
        csr_addr_t addr;
        xlen_t     data;
        logic      valid;
    } csr_wq_entry_t;

    function automatic xlen_t csr_apply(input fu_op_t op, input xlen_t wdata, input xlen_t rdata);
        case (op)
            OP_CSRS: return wdata | rdata;
            OP_CSRC: return ~wdata & rdata;
            default: return wdata;
        endcase
    endfunction

    function automatic logic csr_is_write(input fu_op_t op);
        return op inside {OP_CSRW, OP_CSRS, OP_CSRC};
    endfunction
endpackage

// File: rtl/fu_csr_wq_if.sv
// CSR file port (combinational read, write on the next clock edge) and pipeline squash.
interface csr_if;
    import fu_csr_wq_pkg::*;
    csr_addr_t raddr;
    xlen_t     rdata;
    csr_addr_t waddr;
    xlen_t     wdata;
    logic      wvalid;
    modport master (output raddr, waddr, wdata, wvalid, input rdata);
    modport slave  (input raddr, waddr, wdata, wvalid, output rdata);
endinterface

interface squash_if;
    logic valid;
    modport master (output valid);
    modport slave  (input valid);
endinterface

// File: rtl/fu_csr_wq_wq.sv
// In-order circular write queue with a youngest-match address search used for RaW forwarding.
module csr_wq
    import fu_csr_wq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  id_t           push_id_i,
    input  csr_addr_t     push_addr_i,
    input  xlen_t         push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  csr_addr_t     search_addr_i,
    output logic          hit_o,
    output xlen_t         hit_data_o,
    output csr_wq_entry_t head_o,
    output logic [CNT_W-1:0] count_o,
    output logic          full_o
);
    csr_wq_entry_t    ent_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i & ~full_o & ~flush_i;
    assign head_o  = ent_q[head_q];
    assign count_o = count_q;

    // Walk oldest to youngest from head so the youngest match overwrites older ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int j;
            j = int'(head_q) + k;
            if (j >= DEPTH) j = j - DEPTH;
            if (ent_q[j[PTR_W-1:0]].valid && (ent_q[j[PTR_W-1:0]].addr == search_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = ent_q[j[PTR_W-1:0]].data;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_i)   head_d = ptr_inc(head_q);
            if (do_push) tail_d = ptr_inc(tail_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            end else begin
                if (pop_i)   ent_q[head_q].valid <= 1'b0;
                if (do_push) ent_q[tail_q] <= '{id: push_id_i, addr: push_addr_i, data: push_data_i, valid: 1'b1};
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn) pop_i |-> (count_q != '0));
    a_count_bound:  assert property (@(posedge clk) disable iff (!rstn) count_q <= CNT_W'(DEPTH));
endmodule

// File: rtl/fu_csr_wq.sv
// CSR functional unit: zero-latency issue, privilege check, forwarded read-modify-write,
// and a write queue that drains into the CSR file as instructions retire.
module fu_csr_wq
    import fu_csr_wq_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  bit FWD_EN = 1'b1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  fu_input_t        fuinput_i,
    input  logic             fuinput_i_valid,
    output logic             fuinput_i_ready,
    output fu_output_t       fuoutput_o,
    output logic             fuoutput_o_valid,
    output logic             completion_o_valid,
    output logic             completion_o_ex,
    input  rob_entry_t       retire_entry_i,
    input  logic             retire_entry_i_valid,
    csr_if.master            csr_io,
    squash_if.slave          squash_io,
    output logic [CNT_W-1:0] wq_count_o
);
    logic          is_csr, is_wr, illegal, fire, push, pop, hit, full;
    xlen_t         fwd_data, rd_val;
    csr_wq_entry_t head;

    assign is_csr  = fuinput_i.op inside {OP_CSRR, OP_CSRW, OP_CSRS, OP_CSRC};
    assign is_wr   = csr_is_write(fuinput_i.op);
    assign illegal = is_csr && (fuinput_i.imm[9:8] != PRIV_LVL_M);

    // Issue handshake: an op is taken in the cycle valid && ready are both high; valid may
    // be held without being taken, and every result below is combinational in that cycle.
    assign fuinput_i_ready = rstn & ~full & ~squash_io.valid & (FWD_EN | ~hit);
    assign fire = fuinput_i_valid & fuinput_i_ready;
    assign push = fire & is_wr & ~illegal;
    assign pop  = retire_entry_i_valid & head.valid & (head.id == retire_entry_i.id);

    // A head popping this cycle still forwards: the CSR file only updates at the edge.
    assign rd_val = (FWD_EN && hit) ? fwd_data : csr_io.rdata;

    assign csr_io.raddr  = fuinput_i.imm;
    assign csr_io.waddr  = head.addr;
    assign csr_io.wdata  = head.data;
    assign csr_io.wvalid = pop;

    assign fuoutput_o = '{pc: fuinput_i.pc, id: fuinput_i.id, prd: fuinput_i.prd,
                          rdval: is_csr ? rd_val : '0};
    assign fuoutput_o_valid   = fire & is_csr & ~illegal;
    assign completion_o_valid = fire;
    assign completion_o_ex    = fire & illegal;

    csr_wq #(.DEPTH(DEPTH)) u_wq (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (push),
        .push_id_i    (fuinput_i.id),
        .push_addr_i  (fuinput_i.imm),
        .push_data_i  (csr_apply(fuinput_i.op, fuinput_i.rs1val, rd_val)),
        .pop_i        (pop),
        .flush_i      (squash_io.valid),
        .search_addr_i(fuinput_i.imm),
        .hit_o        (hit),
        .hit_data_o   (fwd_data),
        .head_o       (head),
        .count_o      (wq_count_o),
        .full_o       (full)
    );

    a_retire_head: assert property (@(posedge clk) disable iff (!rstn)
        (retire_entry_i_valid && retire_entry_i.csr_write) |-> (head.valid && head.id == retire_entry_i.id));
endmodule

// File: tb/tb_fu_csr_wq.sv
// Directed bench: a vector table for the single-cycle behaviour plus hand sequences for
// queue-full, no-forward stall, squash and asynchronous reset.
module tb_fu_csr_wq;
  import fu_csr_wq_pkg::*;

  logic clk, rstn, mem_clr;
  fu_input_t in_s;
  rob_entry_t ret_s;
  logic v0, v1, rv0, rv1;
  logic rdy0, rdy1, ov0, ov1, cv0, cv1, ex0, ex1;
  fu_output_t fo0, fo1;
  logic [2:0] cnt0, cnt1;
  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  logic [43:0] exp_q[$];
  logic sb_on;
  int checks, failures;

  csr_if csr0(), csr1();
  squash_if sq0(), sq1();

  fu_csr_wq #(.DEPTH(4), .FWD_EN(1'b1)) u_dut0 (
    .clk(clk), .rstn(rstn), .fuinput_i(in_s), .fuinput_i_valid(v0), .fuinput_i_ready(rdy0),
    .fuoutput_o(fo0), .fuoutput_o_valid(ov0), .completion_o_valid(cv0), .completion_o_ex(ex0),
    .retire_entry_i(ret_s), .retire_entry_i_valid(rv0), .csr_io(csr0.master), .squash_io(sq0.slave),
    .wq_count_o(cnt0));

  fu_csr_wq #(.DEPTH(4), .FWD_EN(1'b0)) u_dut1 (
    .clk(clk), .rstn(rstn), .fuinput_i(in_s), .fuinput_i_valid(v1), .fuinput_i_ready(rdy1),
    .fuoutput_o(fo1), .fuoutput_o_valid(ov1), .completion_o_valid(cv1), .completion_o_ex(ex1),
    .retire_entry_i(ret_s), .retire_entry_i_valid(rv1), .csr_io(csr1.master), .squash_io(sq1.slave),
    .wq_count_o(cnt1));

  // clock / CSR file models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr0.rdata = mem0[csr0.raddr];
  assign csr1.rdata = mem1[csr1.raddr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (csr0.wvalid) mem0[csr0.waddr] <= csr0.wdata;
      if (csr1.wvalid) mem1[csr1.waddr] <= csr1.wdata;
    end
  end

  typedef struct {
    logic vld; fu_op_t op; csr_addr_t addr; xlen_t rs1; id_t id;
    logic rv; id_t rid; logic rcsr;
    logic e_rdy; logic e_ov; logic e_cv; logic e_ex; xlen_t e_rd;
    logic e_wv; csr_addr_t e_wa; xlen_t e_wd; logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [43:0] e;
    if (sb_on && csr0.wvalid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(csr0.wvalid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_waddr", 32'(csr0.waddr), 32'(e[43:32]));
        chk("sb_wdata", csr0.wdata, e[31:0]);
      end
    end
  endtask

  // driver: inputs change at negedge, outputs are checked 1 time unit later
  task automatic drv(input int d, input logic vld, input fu_op_t op, input csr_addr_t addr,
                     input xlen_t rs1, input id_t id, input logic rv, input id_t rid, input logic sq);
    @(negedge clk);
    in_s.op = op; in_s.imm = addr; in_s.rs1val = rs1; in_s.id = id;
    in_s.pc = 32'h2000; in_s.prd = 6'd7;
    if (d == 0) begin v0 = vld; rv0 = rv; v1 = 1'b0; rv1 = 1'b0; end
    else        begin v1 = vld; rv1 = rv; v0 = 1'b0; rv0 = 1'b0; end
    ret_s.id = rid; ret_s.csr_write = rv;
    sq0.valid = sq;
    #1;
    sb_check();
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    v0 = v.vld; in_s.op = v.op; in_s.imm = v.addr; in_s.rs1val = v.rs1; in_s.id = v.id;
    in_s.pc = 32'h1000; in_s.prd = 6'd3;
    rv0 = v.rv; ret_s.id = v.rid; ret_s.csr_write = v.rcsr;
    #1;
    chk($sformatf("v%0d_ready", n), 32'(rdy0), 32'(v.e_rdy));
    chk($sformatf("v%0d_out_valid", n), 32'(ov0), 32'(v.e_ov));
    chk($sformatf("v%0d_compl_valid", n), 32'(cv0), 32'(v.e_cv));
    chk($sformatf("v%0d_compl_ex", n), 32'(ex0), 32'(v.e_ex));
    chk($sformatf("v%0d_rdval", n), fo0.rdval, v.e_rd);
    chk($sformatf("v%0d_wvalid", n), 32'(csr0.wvalid), 32'(v.e_wv));
    chk($sformatf("v%0d_count", n), 32'(cnt0), 32'(v.e_cnt));
    if (v.e_wv) begin
      chk($sformatf("v%0d_waddr", n), 32'(csr0.waddr), 32'(v.e_wa));
      chk($sformatf("v%0d_wdata", n), csr0.wdata, v.e_wd);
    end
    if (v.e_ov) chk($sformatf("v%0d_out_id", n), 32'(fo0.id), 32'(v.id));
  endtask

  initial begin
    checks = 0; failures = 0; sb_on = 1'b0;
    rstn = 1'b0; mem_clr = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    in_s = '0; ret_s = '0; sq0.valid = 1'b0; sq1.valid = 1'b0;

    //           vld   op       addr     rs1     id     rv    rid    rcsr  rdy   ov    cv    ex    rdval   wv    waddr    wdata   cnt
    vecs[0]  = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[1]  = '{1'b1, OP_CSRW, 12'h340, 32'h05, 5'd3,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[2]  = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b1, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 12'h340, 32'h05, 3'd1};
    vecs[3]  = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[4]  = '{1'b1, OP_CSRW, 12'h340, 32'hF0, 5'd4,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h05, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[5]  = '{1'b1, OP_CSRS, 12'h340, 32'h0F, 5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF0, 1'b0, 12'h000, 32'h00, 3'd1};
    vecs[6]  = '{1'b1, OP_CSRR, 12'h340, 32'h00, 5'd6,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFF, 1'b0, 12'h000, 32'h00, 3'd2};
    vecs[7]  = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b1, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 12'h340, 32'hF0, 3'd2};
    vecs[8]  = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 12'h340, 32'hFF, 3'd1};
    vecs[9]  = '{1'b1, OP_CSRR, 12'h340, 32'h00, 5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFF, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[10] = '{1'b1, OP_CSRW, 12'h100, 32'h77, 5'd8,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[11] = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[12] = '{1'b1, OP_CSRC, 12'h340, 32'h0F, 5'd9,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFF, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[13] = '{1'b1, OP_CSRR, 12'h340, 32'h00, 5'd10, 1'b1, 5'd2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF0, 1'b0, 12'h000, 32'h00, 3'd1};
    vecs[14] = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 12'h340, 32'hF0, 3'd1};
    vecs[15] = '{1'b1, OP_NOP,  12'h100, 32'h00, 5'd11, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[16] = '{1'b1, OP_CSRW, 12'h340, 32'h33, 5'd12, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF0, 1'b0, 12'h000, 32'h00, 3'd0};
    vecs[17] = '{1'b1, OP_CSRR, 12'h340, 32'h00, 5'd13, 1'b1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 12'h340, 32'h33, 3'd1};
    vecs[18] = '{1'b0, OP_NOP,  12'h000, 32'h00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 12'h000, 32'h00, 3'd0};

    // reset state, with an issue request held during reset
    repeat (2) @(negedge clk);
    mem_clr = 1'b0; v0 = 1'b1; v1 = 1'b1; in_s.op = OP_CSRW; in_s.imm = 12'h340;
    #1;
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_compl_valid", 32'(cv0), 32'd0);
    chk("rst_compl_ex", 32'(ex0), 32'd0);
    chk("rst_wvalid", 32'(csr0.wvalid), 32'd0);
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_count1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rstn = 1'b1; v0 = 1'b0; v1 = 1'b0;

    for (int i = 0; i < 19; i++) apply_vec(vecs[i], i);

    // FWD_EN=0: a matching queued write stalls issue until it retires
    drv(1, 1'b1, OP_CSRW, 12'h340, 32'hF0, 5'd3, 1'b0, 5'd0, 1'b0);
    chk("t3_a_ready", 32'(rdy1), 32'd1);
    drv(1, 1'b1, OP_CSRS, 12'h340, 32'h0F, 5'd4, 1'b0, 5'd0, 1'b0);
    chk("t3_b_ready", 32'(rdy1), 32'd0);
    chk("t3_b_count", 32'(cnt1), 32'd1);
    drv(1, 1'b1, OP_CSRS, 12'h340, 32'h0F, 5'd4, 1'b1, 5'd3, 1'b0);
    chk("t3_c_ready", 32'(rdy1), 32'd0);
    chk("t3_c_wvalid", 32'(csr1.wvalid), 32'd1);
    chk("t3_c_wdata", csr1.wdata, 32'hF0);
    drv(1, 1'b1, OP_CSRS, 12'h340, 32'h0F, 5'd4, 1'b0, 5'd0, 1'b0);
    chk("t3_d_ready", 32'(rdy1), 32'd1);
    chk("t3_d_rdval", fo1.rdval, 32'hF0);
    chk("t3_d_count", 32'(cnt1), 32'd0);
    drv(1, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b1, 5'd4, 1'b0);
    chk("t3_e_wdata", csr1.wdata, 32'hFF);
    chk("t3_e_wvalid", 32'(csr1.wvalid), 32'd1);
    drv(1, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t3_f_count", 32'(cnt1), 32'd0);

    // full queue: no bypass of a same-cycle pop, pointer wrap on both ends
    sb_on = 1'b1;
    exp_q.push_back({12'h340, 32'h10});
    exp_q.push_back({12'h341, 32'h11});
    exp_q.push_back({12'h342, 32'h12});
    exp_q.push_back({12'h343, 32'h13});
    exp_q.push_back({12'h341, 32'h21});
    drv(0, 1'b1, OP_CSRW, 12'h340, 32'h10, 5'd14, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRW, 12'h341, 32'h11, 5'd15, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRW, 12'h342, 32'h12, 5'd16, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRW, 12'h343, 32'h13, 5'd17, 1'b0, 5'd0, 1'b0);
    chk("t4_d_count", 32'(cnt0), 32'd3);
    drv(0, 1'b1, OP_CSRW, 12'h341, 32'h21, 5'd18, 1'b0, 5'd0, 1'b0);
    chk("t4_full_ready", 32'(rdy0), 32'd0);
    chk("t4_full_count", 32'(cnt0), 32'd4);
    drv(0, 1'b1, OP_CSRW, 12'h341, 32'h21, 5'd18, 1'b1, 5'd14, 1'b0);
    chk("t4_pop_ready", 32'(rdy0), 32'd0);
    chk("t4_pop_wvalid", 32'(csr0.wvalid), 32'd1);
    drv(0, 1'b1, OP_CSRW, 12'h341, 32'h21, 5'd18, 1'b0, 5'd0, 1'b0);
    chk("t4_retry_ready", 32'(rdy0), 32'd1);
    chk("t4_retry_rdval", fo0.rdval, 32'h11);
    chk("t4_retry_count", 32'(cnt0), 32'd3);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b1, 5'd15, 1'b0);
    chk("t4_h_count", 32'(cnt0), 32'd4);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b1, 5'd16, 1'b0);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b1, 5'd17, 1'b0);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b1, 5'd18, 1'b0);
    chk("t4_k_count", 32'(cnt0), 32'd1);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t4_l_count", 32'(cnt0), 32'd0);

    // squash with the head retiring in the same cycle
    exp_q.push_back({12'h340, 32'hA1});
    drv(0, 1'b1, OP_CSRW, 12'h340, 32'hA1, 5'd19, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRW, 12'h341, 32'hA2, 5'd20, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRW, 12'h305, 32'hA3, 5'd21, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b1, OP_CSRR, 12'h340, 32'h0, 5'd22, 1'b1, 5'd19, 1'b1);
    chk("t5_sq_ready", 32'(rdy0), 32'd0);
    chk("t5_sq_out_valid", 32'(ov0), 32'd0);
    chk("t5_sq_wvalid", 32'(csr0.wvalid), 32'd1);
    chk("t5_sq_count", 32'(cnt0), 32'd3);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t5_after_count", 32'(cnt0), 32'd0);
    chk("t5_after_wvalid", 32'(csr0.wvalid), 32'd0);
    drv(0, 1'b1, OP_CSRR, 12'h341, 32'h0, 5'd22, 1'b0, 5'd0, 1'b0);
    chk("t5_read_341", fo0.rdval, 32'h21);
    drv(0, 1'b1, OP_CSRR, 12'h305, 32'h0, 5'd23, 1'b0, 5'd0, 1'b0);
    chk("t5_read_305", fo0.rdval, 32'h0);

    // asynchronous reset with a write in flight
    drv(0, 1'b1, OP_CSRW, 12'h340, 32'h55, 5'd24, 1'b0, 5'd0, 1'b0);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t6_pre_count", 32'(cnt0), 32'd1);
    @(negedge clk);
    rstn = 1'b0; v0 = 1'b1; in_s.op = OP_CSRW; in_s.imm = 12'h100;
    #1;
    chk("t6_rst_count", 32'(cnt0), 32'd0);
    chk("t6_rst_ready", 32'(rdy0), 32'd0);
    chk("t6_rst_compl_valid", 32'(cv0), 32'd0);
    chk("t6_rst_compl_ex", 32'(ex0), 32'd0);
    chk("t6_rst_wvalid", 32'(csr0.wvalid), 32'd0);
    @(negedge clk);
    rstn = 1'b1; v0 = 1'b0;
    #1;
    chk("t6_rel_ready", 32'(rdy0), 32'd1);
    drv(0, 1'b1, OP_CSRR, 12'h340, 32'h0, 5'd26, 1'b0, 5'd0, 1'b0);
    chk("t6_read_340", fo0.rdval, 32'hA1);
    chk("t6_read_count", 32'(cnt0), 32'd0);
    drv(0, 1'b0, OP_NOP, 12'h000, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
